// File: rtl/s_port_arb_if.sv
// Bundle of m_block-side and slave-side signals for one slave port arbiter.
// slave modport: the arbiter's view; master modport: the surrounding fabric's view.
interface s_port_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        m_req;
  logic [1:0]        m_cmd;
  logic [ADDR_W-1:0] m_addr0;
  logic [ADDR_W-1:0] m_addr1;
  logic [DATA_W-1:0] m_wdata0;
  logic [DATA_W-1:0] m_wdata1;
  logic [1:0]        m_req_sent;
  logic [1:0]        m_ack;
  logic [1:0]        m_data_read;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_err;
  logic              s_req;
  logic              s_cmd;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_ack;
  logic              s_resp;
  logic [DATA_W-1:0] s_rdata;

  modport slave (
    input  m_req, m_cmd, m_addr0, m_addr1, m_wdata0, m_wdata1, s_ack, s_resp, s_rdata,
    output m_req_sent, m_ack, m_data_read, m_rdata, m_err, s_req, s_cmd, s_addr, s_wdata
  );

  modport master (
    output m_req, m_cmd, m_addr0, m_addr1, m_wdata0, m_wdata1, s_ack, s_resp, s_rdata,
    input  m_req_sent, m_ack, m_data_read, m_rdata, m_err, s_req, s_cmd, s_addr, s_wdata
  );
endinterface

// File: rtl/s_port_arb.sv
// Slave-side round-robin arbiter between two m_block request holders; all outputs registered.
// Optional ack/resp timeout enabled by defining S_ARB_TIMEOUT_EN.
module s_port_arb #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  s_port_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;

  state_t            r_state, w_state;
  logic              r_g, w_g;
  logic              r_ptr, w_ptr;
  logic              r_cmd, w_cmd;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic              r_s_req, w_s_req;
  logic [1:0]        r_req_sent, w_req_sent;
  logic [1:0]        r_ack, w_ack;
  logic [1:0]        r_dread, w_dread;
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic              w_sel;
  logic              w_done;
  logic              w_enter;

  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("TIMEOUT_W must be at least 1");
  end

`ifdef S_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {TIMEOUT_W{1'b1}} - 1'b1;
  logic [TIMEOUT_W-1:0] r_cnt, w_cnt;
  logic [1:0]           r_err, w_err;
`endif

  // Both requesting: rr_ptr names the preferred master.
  assign w_sel = (bus.m_req == 2'b11) ? r_ptr : bus.m_req[1];

  always_comb begin
    w_state    = r_state;
    w_g        = r_g;
    w_ptr      = r_ptr;
    w_cmd      = r_cmd;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_s_req    = r_s_req;
    w_req_sent = '0;
    w_ack      = '0;
    w_dread    = '0;
    w_rdata    = r_rdata;
    w_done     = 1'b0;
    w_enter    = 1'b0;
    case (r_state)
      IDLE: if (|bus.m_req) begin
        w_g     = w_sel;
        w_cmd   = bus.m_cmd[w_sel];
        w_addr  = w_sel ? bus.m_addr1 : bus.m_addr0;
        w_wdata = w_sel ? bus.m_wdata1 : bus.m_wdata0;
        w_state = SEND;
        w_enter = 1'b1;
      end
      SEND: begin
        // s_req is still low only in the first SEND cycle.
        if (!r_s_req) begin
          w_s_req        = 1'b1;
          w_req_sent[r_g] = 1'b1;
        end else if (bus.s_ack) begin
          w_s_req    = 1'b0;
          w_ack[r_g] = 1'b1;
          if (r_cmd) begin
            w_state = IDLE;
            w_done  = 1'b1;
          end else begin
            w_state = WAIT_RESP;
            w_enter = 1'b1;
          end
        end
      end
      WAIT_RESP: if (bus.s_resp) begin
        w_rdata      = bus.s_rdata;
        w_dread[r_g] = 1'b1;
        w_state      = IDLE;
        w_done       = 1'b1;
      end
      default: begin
        w_state = IDLE;
        w_s_req = 1'b0;
      end
    endcase

`ifdef S_ARB_TIMEOUT_EN
    w_err = '0;
    w_cnt = r_cnt + 1'b1;
    // Fires on the edge at which the counter would reach its all-ones value.
    if (r_state != IDLE && w_state == r_state && r_cnt == CNT_LAST) begin
      w_err[r_g] = 1'b1;
      w_s_req    = 1'b0;
      w_req_sent = '0;
      w_state    = IDLE;
      w_done     = 1'b1;
    end
    if (w_enter || w_done || r_state == IDLE) w_cnt = '0;
`endif

    if (w_done) w_ptr = ~r_g;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_g        <= 1'b0;
      r_ptr      <= 1'b0;
      r_cmd      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_s_req    <= 1'b0;
      r_req_sent <= '0;
      r_ack      <= '0;
      r_dread    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state;
      r_g        <= w_g;
      r_ptr      <= w_ptr;
      r_cmd      <= w_cmd;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_s_req    <= w_s_req;
      r_req_sent <= w_req_sent;
      r_ack      <= w_ack;
      r_dread    <= w_dread;
      r_rdata    <= w_rdata;
    end
  end

`ifdef S_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= '0;
    end else begin
      r_cnt <= w_cnt;
      r_err <= w_err;
    end
  end
  assign bus.m_err = r_err;
`else
  assign bus.m_err = '0;
`endif

  assign bus.m_req_sent  = r_req_sent;
  assign bus.m_ack       = r_ack;
  assign bus.m_data_read = r_dread;
  assign bus.m_rdata     = r_rdata;
  assign bus.s_req       = r_s_req;
  assign bus.s_cmd       = r_cmd;
  assign bus.s_addr      = r_addr;
  assign bus.s_wdata     = r_wdata;
endmodule

// File: tb/tb_s_port_arb.sv
// Directed + randomized bench for s_port_arb; a transaction-level model predicts grants and pulses.
module tb_s_port_arb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  s_port_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  s_port_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int          n_chk  = 0;
  int          n_pass = 0;
  int          pref   = 0;        // master preferred on contention
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] oh(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s"}, {bus.s_req, bus.s_cmd, bus.s_addr, bus.s_wdata}, '0);
    chk({tag, "_m"}, {bus.m_req_sent, bus.m_ack, bus.m_data_read, bus.m_err, bus.m_rdata}, '0);
  endtask

  // One full transaction; bench is just after an edge with the DUT in IDLE.
  task automatic do_txn(input logic [1:0] req, input logic [1:0] cmd,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input int ack_dly, input int resp_dly, input logic [31:0] rd,
                        input bit early_resp, input bit keep);
    int g;
    logic gc;
    logic [31:0] ga, gw;
    g  = (req == 2'b11) ? pref : (req[1] ? 1 : 0);
    gc = cmd[g];
    ga = (g == 1) ? a1 : a0;
    gw = (g == 1) ? w1 : w0;
    bus.m_req = req; bus.m_cmd = cmd;
    bus.m_addr0 = a0; bus.m_addr1 = a1; bus.m_wdata0 = w0; bus.m_wdata1 = w1;
    tick();
    chk("grant_sreq_low", {bus.s_req, bus.m_req_sent}, 3'b000);
    if (!keep) begin
      bus.m_req = 2'($urandom); bus.m_cmd = 2'($urandom);
      bus.m_addr0 = $urandom; bus.m_addr1 = $urandom;
      bus.m_wdata0 = $urandom; bus.m_wdata1 = $urandom;
    end
    tick();
    chk("s_req", bus.s_req, 1'b1);
    chk("req_sent", bus.m_req_sent, oh(g));
    chk("s_fields", {bus.s_cmd, bus.s_addr, bus.s_wdata}, {gc, ga, gw});
    for (int i = 0; i < ack_dly; i++) begin
      bus.s_resp = 1'($urandom); bus.s_rdata = $urandom;
      tick();
      chk("hold", {bus.s_req, bus.m_req_sent, bus.m_ack, bus.m_data_read}, 7'b1000000);
    end
    bus.s_ack = 1'b1;
    bus.s_resp = early_resp; bus.s_rdata = $urandom;
    tick();
    bus.s_ack = 1'b0; bus.s_resp = 1'b0;
    chk("m_ack", bus.m_ack, oh(g));
    chk("ack_sreq_drop", {bus.s_req, bus.m_data_read}, 3'b000);
    chk("rdata_held", bus.m_rdata, exp_rdata);
    if (!gc) begin
      for (int i = 0; i < resp_dly; i++) begin
        bus.s_rdata = $urandom;
        tick();
        chk("wait_resp", {bus.s_req, bus.m_ack, bus.m_data_read}, 5'b0);
      end
      bus.s_resp = 1'b1; bus.s_rdata = rd;
      tick();
      bus.s_resp = 1'b0; bus.s_rdata = $urandom;
      exp_rdata = rd;
      chk("data_read", bus.m_data_read, oh(g));
      chk("m_rdata", bus.m_rdata, rd);
    end
    chk("m_err", bus.m_err, 2'b00);
    pref = 1 - g;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.m_req = '0; bus.m_cmd = '0; bus.m_addr0 = '0; bus.m_addr1 = '0;
    bus.m_wdata0 = '0; bus.m_wdata1 = '0;
    bus.s_ack = 1'b0; bus.s_resp = 1'b0; bus.s_rdata = '0;

    // Reset state and idle with no requests
    #1;
    chk_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_sreq", {bus.s_req, bus.m_req_sent}, 3'b000);
    end

    // Directed write from M0, read from M1
    do_txn(2'b01, 2'b01, 32'h10, 32'h0, 32'hA5, 32'h0, 2, 0, 32'h0, 1'b0, 1'b0);
    do_txn(2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0, 1, 3, 32'hDEADBEEF, 1'b0, 1'b0);

    // Contention: both held across four back-to-back transactions -> M0, M1, M0, M1
    for (int i = 0; i < 4; i++)
      do_txn(2'b11, 2'b11, 32'h100 + i, 32'h200 + i, 32'hAAAA0000 + i, 32'hBBBB0000 + i,
             0, 0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] rq;
      rq = 2'($urandom_range(1, 3));
      do_txn(rq, 2'($urandom), $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom,
             1'($urandom), 1'($urandom));
    end

    // Reset while waiting for read data
    bus.m_req = 2'b01; bus.m_cmd = 2'b00;
    tick();
    bus.m_req = 2'b00;
    tick(); tick();
    bus.s_ack = 1'b1;
    tick();
    bus.s_ack = 1'b0;
    chk("pre_reset_ack", bus.m_ack, 2'b01);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    bus.s_resp = 1'b1; bus.s_rdata = 32'h12345678;
    tick();
    chk("reset_no_dread", {bus.m_data_read, bus.s_req}, 3'b000);
    rst_n = 1'b1; bus.s_resp = 1'b0;
    tick();
    chk("post_reset_dread", {bus.m_data_read, bus.s_req}, 3'b000);
    pref = 0; exp_rdata = '0;
    do_txn(2'b01, 2'b01, 32'h44, 32'h0, 32'h55, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
    do_txn(2'b11, 2'b00, 32'h66, 32'h77, 32'h0, 32'h0, 1, 1, 32'hCAFEF00D, 1'b0, 1'b0);

    // Slave never acknowledges
    bus.m_req = 2'b11; bus.m_cmd = 2'b11;
    tick();
    bus.m_req = 2'b00;
`ifdef S_ARB_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("to_no_err_yet", {bus.m_err, bus.s_req}, 3'b001 & {3{i > 0}});
    end
    tick();
    chk("to_err", bus.m_err, oh(pref));
    chk("to_sreq_drop", bus.s_req, 1'b0);
    tick();
    chk("to_err_pulse", bus.m_err, 2'b00);
    pref = 1 - pref;
    do_txn(2'b11, 2'b01, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 32'h0, 1'b0, 1'b0);
`else
    tick();
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("stall", {bus.m_err, bus.s_req}, 3'b001);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
